// File: rtl/matmul_ctrl_module_if.sv
// APB-style register bus between the host and the matmul controller.
// Zero-wait-state slave; pready is tied high by the slave.
interface matmul_ctrl_module_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned BUS_WIDTH  = 16
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [BUS_WIDTH-1:0]  pwdata;
    logic [BUS_WIDTH-1:0]  prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/matmul_ctrl_module.sv
// Register-mapped controller for one systolic matrix-multiply datapath.
// Holds operands and dims, runs one multiply per START, captures result and flags.
module matmul_ctrl_module #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT    = 64,
    localparam int unsigned MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int unsigned NUM_PE    = MAX_DIM * MAX_DIM,
    localparam int unsigned OP_W      = NUM_PE * DATA_WIDTH,
    localparam int unsigned RES_W     = 2 * OP_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    matmul_ctrl_module_if.slave     apb,
    output logic                    mul_start_o,
    output logic [2:0]              mul_n_dim_o,
    output logic [2:0]              mul_k_dim_o,
    output logic [2:0]              mul_m_dim_o,
    output logic [OP_W-1:0]         mul_a_matrix_o,
    output logic [OP_W-1:0]         mul_b_matrix_o,
    input  logic [RES_W-1:0]        mul_c_matrix_i,
    input  logic [NUM_PE-1:0]       mul_flags_i,
    input  logic                    mul_finish_i,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam int unsigned PG_W = ADDR_WIDTH - 3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                              state_q, state_d;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]   a_q, b_q;
    logic [2*MAX_DIM-1:0][BUS_WIDTH-1:0] c_q;
    logic [NUM_PE-1:0]                   flags_q;
    logic [8:0]                          dims_q, dims_d;
    logic                                dim_err_q, dim_err_d;
    logic                                timeout_q, timeout_d;
    logic [WD_W-1:0]                     wdog_q, wdog_d;
    logic                                capture;

    logic            running, access, wr_access;
    logic [PG_W-1:0] page;
    logic [2:0]      off;
    logic            is_ctrl, is_stat, is_a, is_b, is_res, mapped, ro;
    logic            ctrl_wr, a_wr, b_wr;
    logic [2:0]      n_wr, k_wr, m_wr;
    logic            dims_ok;

    assign running   = (state_q == StRun);
    assign access    = apb.psel & apb.penable;
    assign wr_access = access & apb.pwrite;

    // Operand and result windows are 8-word pages; the low 3 bits index the row/word.
    assign page    = apb.paddr[ADDR_WIDTH-1:3];
    assign off     = apb.paddr[2:0];
    assign is_ctrl = (apb.paddr == ADDR_WIDTH'(0));
    assign is_stat = (apb.paddr == ADDR_WIDTH'(1));
    assign is_a    = (page == PG_W'(1)) && (32'(off) < MAX_DIM);
    assign is_b    = (page == PG_W'(2)) && (32'(off) < MAX_DIM);
    assign is_res  = (page == PG_W'(3)) && (32'(off) < 2 * MAX_DIM);
    assign mapped  = is_ctrl | is_stat | is_a | is_b | is_res;
    assign ro      = is_stat | is_res;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = access & (~mapped | (apb.pwrite & (ro | running)));

    assign ctrl_wr = wr_access & is_ctrl & ~running;
    assign a_wr    = wr_access & is_a & ~running;
    assign b_wr    = wr_access & is_b & ~running;

    assign n_wr    = apb.pwdata[4:2];
    assign k_wr    = apb.pwdata[7:5];
    assign m_wr    = apb.pwdata[10:8];
    assign dims_ok = (n_wr != 3'd0) && (32'(n_wr) <= MAX_DIM) &&
                     (k_wr != 3'd0) && (32'(k_wr) <= MAX_DIM) &&
                     (m_wr != 3'd0) && (32'(m_wr) <= MAX_DIM);

    always_comb begin
        apb.prdata = '0;
        if (access) begin
            if (is_ctrl) begin
                apb.prdata = BUS_WIDTH'({dims_q, 2'b00});
            end else if (is_stat) begin
                apb.prdata = BUS_WIDTH'({flags_q, timeout_q, dim_err_q, done_o, busy_o});
            end
            for (int unsigned r = 0; r < MAX_DIM; r++) begin
                if (is_a && off == 3'(r)) apb.prdata = a_q[r];
                if (is_b && off == 3'(r)) apb.prdata = b_q[r];
            end
            for (int unsigned w = 0; w < 2 * MAX_DIM; w++) begin
                if (is_res && off == 3'(w)) apb.prdata = c_q[w];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        dims_d    = dims_q;
        dim_err_d = dim_err_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;
        capture   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (ctrl_wr) begin
                    dims_d = apb.pwdata[10:2];
                    if (apb.pwdata[0]) begin
                        if (dims_ok) begin
                            state_d   = StRun;
                            dim_err_d = 1'b0;
                            timeout_d = 1'b0;
                            wdog_d    = '0;
                        end else begin
                            dim_err_d = 1'b1;
                        end
                    end
                end
            end
            StRun: begin
                if (mul_finish_i) begin
                    state_d = StDone;
                    capture = 1'b1;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            dims_q    <= '0;
            dim_err_q <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            dims_q    <= dims_d;
            dim_err_q <= dim_err_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            flags_q <= '0;
        end else begin
            for (int unsigned r = 0; r < MAX_DIM; r++) begin
                if (a_wr && off == 3'(r)) a_q[r] <= apb.pwdata;
                if (b_wr && off == 3'(r)) b_q[r] <= apb.pwdata;
            end
            if (capture) begin
                c_q     <= mul_c_matrix_i;
                flags_q <= mul_flags_i;
            end
        end
    end

    // Start/busy decode straight from state so reset drops them asynchronously.
    assign mul_start_o    = running;
    assign busy_o         = running;
    assign done_o         = (state_q == StDone);
    assign mul_n_dim_o    = dims_q[2:0];
    assign mul_k_dim_o    = dims_q[5:3];
    assign mul_m_dim_o    = dims_q[8:6];
    assign mul_a_matrix_o = a_q;
    assign mul_b_matrix_o = b_q;
endmodule

// File: tb/tb_matmul_ctrl_module.sv
// Self-checking bench for matmul_ctrl_module: register table plus multi-cycle sequences
// against a behavioural multiplier stub with programmable latency.
module tb_matmul_ctrl_module;
    localparam int DW   = 8;
    localparam int BW   = 16;
    localparam int AW   = 5;
    localparam int MD   = 2;
    localparam int NPE  = MD * MD;
    localparam int OPW  = NPE * DW;
    localparam int RESW = 2 * OPW;
    localparam logic [RESW-1:0] JUNK = {(RESW / 16){16'hDEAD}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_ctrl_module_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    logic            mul_start;
    logic [2:0]      n_dim, k_dim, m_dim;
    logic [OPW-1:0]  a_img, b_img;
    logic [RESW-1:0] c_img = JUNK;
    logic [NPE-1:0]  flags = '1;
    logic            fin;
    logic            busy, done;

    matmul_ctrl_module #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT(64)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .apb            (bus),
        .mul_start_o    (mul_start),
        .mul_n_dim_o    (n_dim),
        .mul_k_dim_o    (k_dim),
        .mul_m_dim_o    (m_dim),
        .mul_a_matrix_o (a_img),
        .mul_b_matrix_o (b_img),
        .mul_c_matrix_i (c_img),
        .mul_flags_i    (flags),
        .mul_finish_i   (fin),
        .busy_o         (busy),
        .done_o         (done)
    );

    // Multiplier stub: element (r,c) of A*B goes to 16-bit slot c*MD+r.
    function automatic logic [RESW-1:0] mul_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                                  input logic [2:0] n, input logic [2:0] k,
                                                  input logic [2:0] m);
        logic [RESW-1:0] res;
        logic [2*DW-1:0] acc;
        res = '0;
        for (int i = 0; i < MD; i++) begin
            for (int j = 0; j < MD; j++) begin
                acc = '0;
                for (int p = 0; p < MD; p++) begin
                    if (i < 32'(n) && j < 32'(m) && p < 32'(k))
                        acc = acc + 16'(a[(i*MD+p)*DW +: DW]) * 16'(b[(p*MD+j)*DW +: DW]);
                end
                res[(j*MD+i)*2*DW +: 2*DW] = acc;
            end
        end
        return res;
    endfunction

    int unsigned    stub_lat = 6;
    bit             stub_en = 1'b1;
    logic [NPE-1:0] flags_pat = '0;
    logic           force_fin = 1'b0;
    int unsigned    stub_cnt = 0;
    logic           stub_fin = 1'b0;

    always @(posedge clk) begin
        if (mul_start && stub_en) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == stub_lat - 1) begin
                stub_fin <= 1'b1;
                c_img    <= mul_model(a_img, b_img, n_dim, k_dim, m_dim);
                flags    <= flags_pat;
            end else begin
                stub_fin <= 1'b0;
                c_img    <= JUNK;
                flags    <= '1;
            end
        end else begin
            stub_cnt <= 0;
            stub_fin <= 1'b0;
            c_img    <= JUNK;
            flags    <= '1;
        end
    end
    assign fin = stub_fin | force_fin;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic apb(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                       output logic [BW-1:0] rdata, output logic err);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(negedge clk);
        bus.penable = 1'b1;
        #1;
        rdata = bus.prdata;
        err   = bus.pslverr;
        @(negedge clk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic wr_chk(input string name, input logic [AW-1:0] addr, input logic [BW-1:0] d,
                          input logic exp_err);
        logic [BW-1:0] rd;
        logic          err;
        apb(1'b1, addr, d, rd, err);
        check({name, " slverr"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] addr, input logic [BW-1:0] exp);
        logic [BW-1:0] rd;
        logic          err;
        apb(1'b0, addr, '0, rd, err);
        check(name, 32'(rd), 32'(exp));
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({name, " done_o"}, 32'(done), 1);
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [BW-1:0] exp_rd;
        bit            exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [BW-1:0] rd;
        logic          err;
        bit            saw_start;
        int            n;

        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0;  bus.pwdata = '0;

        vecs.push_back('{0, 5'h00, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h01, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h08, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h18, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h05, 16'h0000, 16'h0000, 1});
        vecs.push_back('{0, 5'h1C, 16'h0000, 16'h0000, 1});
        vecs.push_back('{1, 5'h08, 16'h0201, 16'h0000, 0});
        vecs.push_back('{1, 5'h09, 16'h0403, 16'h0000, 0});
        vecs.push_back('{1, 5'h10, 16'h0001, 16'h0000, 0});
        vecs.push_back('{1, 5'h11, 16'h0100, 16'h0000, 0});
        vecs.push_back('{0, 5'h08, 16'h0000, 16'h0201, 0});
        vecs.push_back('{0, 5'h09, 16'h0000, 16'h0403, 0});
        vecs.push_back('{0, 5'h11, 16'h0000, 16'h0100, 0});
        vecs.push_back('{1, 5'h01, 16'h00FF, 16'h0000, 1});
        vecs.push_back('{1, 5'h18, 16'h1234, 16'h0000, 1});
        vecs.push_back('{1, 5'h0A, 16'hBEEF, 16'h0000, 1});
        vecs.push_back('{0, 5'h01, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h18, 16'h0000, 16'h0000, 0});
        vecs.push_back('{1, 5'h00, 16'h0248, 16'h0000, 0});
        vecs.push_back('{0, 5'h00, 16'h0000, 16'h0248, 0});
        vecs.push_back('{0, 5'h01, 16'h0000, 16'h0000, 0});
        vecs.push_back('{0, 5'h0A, 16'h0000, 16'h0000, 1});

        repeat (2) @(negedge clk);
        check("reset mul_start", 32'(mul_start), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset pready", 32'(bus.pready), 1);
        check("reset prdata", 32'(bus.prdata), 0);
        check("reset pslverr", 32'(bus.pslverr), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle n_dim", 32'(n_dim), 0);
        check("idle a_img", 32'(a_img), 0);

        foreach (vecs[i]) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
            check($sformatf("vec%0d slverr", i), 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end
        check("dims driven n", 32'(n_dim), 2);
        check("dims driven m", 32'(m_dim), 2);
        check("a_img image", 32'(a_img), 32'h0403_0201);

        // Basic 2x2 multiply with identity B.
        wr_chk("start1", 5'h00, 16'h0249, 1'b0);
        check("start1 busy", 32'(busy), 1);
        check("start1 mul_start", 32'(mul_start), 1);
        wait_done("op1", 100);
        check("op1 busy", 32'(busy), 0);
        check("op1 mul_start", 32'(mul_start), 0);
        rd_chk("op1 c0", 5'h18, 16'h0001);
        rd_chk("op1 c1", 5'h19, 16'h0003);
        rd_chk("op1 c2", 5'h1A, 16'h0002);
        rd_chk("op1 c3", 5'h1B, 16'h0004);
        rd_chk("op1 status", 5'h01, 16'h0002);
        rd_chk("op1 control", 5'h00, 16'h0248);

        // START with invalid dims.
        wr_chk("dimerr n0", 5'h00, 16'h0241, 1'b0);
        saw_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mul_start) saw_start = 1'b1;
        end
        check("dimerr no start", 32'(saw_start), 0);
        rd_chk("dimerr status", 5'h01, 16'h0006);
        rd_chk("dimerr control", 5'h00, 16'h0240);
        wr_chk("dimerr k3", 5'h00, 16'h0269, 1'b0);
        check("dimerr k3 busy", 32'(busy), 0);
        rd_chk("dimerr k3 status", 5'h01, 16'h0006);

        // Bus traffic while busy.
        stub_lat = 12;
        wr_chk("start2", 5'h00, 16'h0249, 1'b0);
        rd_chk("run status", 5'h01, 16'h0001);
        wr_chk("busy write A", 5'h08, 16'hFFFF, 1'b1);
        rd_chk("busy A unchanged", 5'h08, 16'h0201);
        rd_chk("busy old result", 5'h18, 16'h0001);
        wr_chk("busy write ctrl", 5'h00, 16'h0249, 1'b1);
        check("still busy", 32'(busy), 1);
        wait_done("op2", 100);
        rd_chk("op2 c0", 5'h18, 16'h0001);
        rd_chk("op2 c3", 5'h1B, 16'h0004);

        // Finish outside RUN is ignored.
        force_fin = 1'b1;
        @(negedge clk);
        force_fin = 1'b0;
        @(negedge clk);
        check("stray fin mul_start", 32'(mul_start), 0);
        rd_chk("stray fin c1", 5'h19, 16'h0003);
        rd_chk("stray fin status", 5'h01, 16'h0002);

        // Watchdog timeout.
        stub_en = 1'b0;
        wr_chk("start3", 5'h00, 16'h0249, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("timeout run cycles", 32'(n), 64);
        check("timeout done_o", 32'(done), 0);
        check("timeout mul_start", 32'(mul_start), 0);
        rd_chk("timeout status", 5'h01, 16'h0008);
        rd_chk("timeout result kept", 5'h18, 16'h0001);

        // Saturating operands; flags captured at finish.
        stub_en   = 1'b1;
        stub_lat  = 6;
        flags_pat = 4'b1010;
        wr_chk("ovf A0", 5'h08, 16'h7F7F, 1'b0);
        wr_chk("ovf A1", 5'h09, 16'h7F7F, 1'b0);
        wr_chk("ovf B0", 5'h10, 16'h7F7F, 1'b0);
        wr_chk("ovf B1", 5'h11, 16'h7F7F, 1'b0);
        wr_chk("start4", 5'h00, 16'h0249, 1'b0);
        wait_done("op4", 100);
        rd_chk("ovf status", 5'h01, 16'h00A2);
        rd_chk("ovf c0", 5'h18, 16'h7E02);
        rd_chk("ovf c3", 5'h1B, 16'h7E02);

        // Reset mid-RUN.
        stub_en   = 1'b0;
        flags_pat = '0;
        wr_chk("start5", 5'h00, 16'h0249, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset mul_start", 32'(mul_start), 0);
        check("async reset busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("post reset status", 5'h01, 16'h0000);
        rd_chk("post reset c0", 5'h18, 16'h0000);
        rd_chk("post reset A0", 5'h08, 16'h0000);
        rd_chk("post reset control", 5'h00, 16'h0000);
        stub_en = 1'b1;
        wr_chk("re A0", 5'h08, 16'h0201, 1'b0);
        wr_chk("re A1", 5'h09, 16'h0403, 1'b0);
        wr_chk("re B0", 5'h10, 16'h0001, 1'b0);
        wr_chk("re B1", 5'h11, 16'h0100, 1'b0);
        wr_chk("start6", 5'h00, 16'h0249, 1'b0);
        wait_done("op6", 100);
        rd_chk("op6 c2", 5'h1A, 16'h0002);
        rd_chk("op6 status", 5'h01, 16'h0002);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1);
    end
endmodule
